counter_mmio_reader: RTL and testbench

- Memory-mapped read/control port for the core's free-running performance counters: the cycle counter and the retired-instruction counter.
- Takes the DWIDTH-bit counter values as inputs and extends each to 2*DWIDTH bits by tracking wrap-around.
- Serves software loads/stores over a valid/ready request/response handshake; a load of a counter's low word snapshots its high word so multi-word reads are coherent.
- Sits on the MMIO path between the memory stage and the counter blocks, and drives their clear input.

---
 rtl/counter_mmio_reader_pkg.sv | 38 +++
 rtl/counter_mmio_reader_counter_ext.sv | 60 ++++++
 rtl/counter_mmio_reader.sv | 131 +++++++++++++
 tb/tb_counter_mmio_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mmio_reader_pkg.sv
// Shared definitions for the performance-counter MMIO reader: window offsets,
// FSM state encoding and the offset decoder.
package counter_mmio_reader_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_CYCLE_LO = 3'd0,
    SEL_CYCLE_HI = 3'd1,
    SEL_INST_LO  = 3'd2,
    SEL_INST_HI  = 3'd3,
    SEL_CTRL     = 3'd4,
    SEL_NONE     = 3'd5
  } sel_e;

  localparam logic [31:0] CYCLE_LO = 32'h0000_0000;
  localparam logic [31:0] CYCLE_HI = 32'h0000_0004;
  localparam logic [31:0] INST_LO  = 32'h0000_0008;
  localparam logic [31:0] INST_HI  = 32'h0000_000C;
  localparam logic [31:0] CTRL     = 32'h0000_0010;

  function automatic sel_e decode_offset(input logic [31:0] word_off);
    sel_e sel;
    case (word_off)
      CYCLE_LO: sel = SEL_CYCLE_LO;
      CYCLE_HI: sel = SEL_CYCLE_HI;
      INST_LO:  sel = SEL_INST_LO;
      INST_HI:  sel = SEL_INST_HI;
      CTRL:     sel = SEL_CTRL;
      default:  sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/counter_mmio_reader_counter_ext.sv
// Extends one free-running counter with a wrap-tracking high word and keeps
// the high-word shadow that a low-word load snapshots.
module counter_ext #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_cnt,
  input  logic              i_clr,
  input  logic              i_snap,
  output logic [DWIDTH-1:0] o_shadow
);

  logic [DWIDTH-1:0] r_prev;
  logic [DWIDTH-1:0] r_hi;
  logic [DWIDTH-1:0] r_shadow;
  logic              r_clr_d;
  logic              w_wrap;

  // The drop to zero right after a clear is not a wrap, so it is masked by r_clr_d.
  assign w_wrap = (i_cnt < r_prev) && !r_clr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev  <= '0;
      r_clr_d <= 1'b0;
    end else begin
      r_prev  <= i_cnt;
      r_clr_d <= i_clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
    end else if (i_clr) begin
      r_hi <= '0;
    end else if (w_wrap) begin
      r_hi <= r_hi + {{(DWIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_hi <= r_hi;
    end
  end

  // Shadow takes the pre-increment high word, matching the pre-wrap low sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (i_clr) begin
      r_shadow <= '0;
    end else if (i_snap) begin
      r_shadow <= r_hi;
    end else begin
      r_shadow <= r_shadow;
    end
  end

  assign o_shadow = r_shadow;

endmodule

// File: rtl/counter_mmio_reader.sv
// MMIO read/control port for the cycle and retired-instruction counters:
// request/response FSM, offset decode and the counter clear pulse.
module counter_mmio_reader
  import counter_mmio_reader_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] cycle_cnt,
  input  logic [DWIDTH-1:0] inst_cnt,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              counter_clr
);

  state_e            r_state;
  state_e            w_state_next;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;
  logic              r_counter_clr;
  logic [31:0]       w_word_off;
  sel_e              w_sel;
  logic              w_accept;
  logic              w_snap_cycle;
  logic              w_snap_inst;
  logic              w_clr_req;
  logic [DWIDTH-1:0] w_rdata;
  logic              w_err;
  logic [DWIDTH-1:0] w_cycle_shadow;
  logic [DWIDTH-1:0] w_inst_shadow;
  logic              w_unused;

  assign w_word_off   = 32'({req_addr[AWIDTH-1:2], 2'b00});
  assign w_sel        = decode_offset(w_word_off);
  assign w_accept     = (r_state == IDLE) && req_valid;
  assign w_snap_cycle = w_accept && !req_we && (w_sel == SEL_CYCLE_LO);
  assign w_snap_inst  = w_accept && !req_we && (w_sel == SEL_INST_LO);
  assign w_clr_req    = w_accept && req_we && (w_sel == SEL_CTRL) && req_wdata[0];
  assign w_unused     = ^{req_addr[1:0], req_wdata[DWIDTH-1:1]};

  counter_ext #(.DWIDTH(DWIDTH)) u_cycle_ext (
    .clk      (clk),
    .rst      (rst),
    .i_cnt    (cycle_cnt),
    .i_clr    (r_counter_clr),
    .i_snap   (w_snap_cycle),
    .o_shadow (w_cycle_shadow)
  );

  counter_ext #(.DWIDTH(DWIDTH)) u_inst_ext (
    .clk      (clk),
    .rst      (rst),
    .i_cnt    (inst_cnt),
    .i_clr    (r_counter_clr),
    .i_snap   (w_snap_inst),
    .o_shadow (w_inst_shadow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    w_state_next = req_valid ? RESP : IDLE;
      RESP:    w_state_next = resp_ready ? IDLE : RESP;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE:    req_ready  = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Stores never return data; any unmapped offset flags an error.
  always_comb begin
    w_rdata = '0;
    w_err   = 1'b0;
    case (w_sel)
      SEL_CYCLE_LO: w_rdata = req_we ? '0 : cycle_cnt;
      SEL_CYCLE_HI: w_rdata = req_we ? '0 : w_cycle_shadow;
      SEL_INST_LO:  w_rdata = req_we ? '0 : inst_cnt;
      SEL_INST_HI:  w_rdata = req_we ? '0 : w_inst_shadow;
      SEL_CTRL:     w_rdata = '0;
      SEL_NONE:     w_err   = 1'b1;
      default:      w_err   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata       <= '0;
      r_err         <= 1'b0;
      r_counter_clr <= 1'b0;
    end else begin
      r_counter_clr <= w_clr_req;
      if (w_accept) begin
        r_rdata <= w_rdata;
        r_err   <= w_err;
      end else begin
        r_rdata <= r_rdata;
        r_err   <= r_err;
      end
    end
  end

  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;
  assign counter_clr = r_counter_clr;

endmodule

// File: tb/tb_counter_mmio_reader.sv
// Self-checking bench for counter_mmio_reader: directed scenarios with literal
// expectations, then randomized traffic compared cycle by cycle to a model.
module tb_counter_mmio_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cycle_cnt;
  logic [31:0] inst_cnt;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        counter_clr;

  int n_chk = 0;
  int n_err = 0;

  counter_mmio_reader #(.DWIDTH(32), .AWIDTH(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .cycle_cnt   (cycle_cnt),
    .inst_cnt    (inst_cnt),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .counter_clr (counter_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: number of wraps seen since the last clear, the shadowed
  // wrap count per counter, and the outstanding response.
  logic [31:0] m_prev   [2];
  logic [31:0] m_wraps  [2];
  logic [31:0] m_shadow [2];
  logic        m_busy, m_err, m_clr, m_clr_gap;
  logic [31:0] m_rdata;
  logic [31:0] t_cnt [2];
  logic        t_acc;
  logic [4:0]  t_word;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_prev[c] = 32'd0; m_wraps[c] = 32'd0; m_shadow[c] = 32'd0;
      end
      m_busy = 1'b0; m_err = 1'b0; m_clr = 1'b0; m_clr_gap = 1'b0; m_rdata = 32'd0;
    end else begin
      t_cnt[0] = cycle_cnt;
      t_cnt[1] = inst_cnt;
      t_acc    = !m_busy && req_valid;
      t_word   = {req_addr[4:2], 2'b00};
      if (t_acc) begin
        m_busy  = 1'b1;
        m_rdata = 32'd0;
        m_err   = (t_word > 5'h10);
        if (!req_we) begin
          if (t_word == 5'h00) m_rdata = cycle_cnt;
          if (t_word == 5'h04) m_rdata = m_shadow[0];
          if (t_word == 5'h08) m_rdata = inst_cnt;
          if (t_word == 5'h0C) m_rdata = m_shadow[1];
        end
      end else if (m_busy && resp_ready) begin
        m_busy = 1'b0;
      end
      for (int c = 0; c < 2; c++) begin
        if (m_clr) begin
          m_wraps[c]  = 32'd0;
          m_shadow[c] = 32'd0;
        end else begin
          if (t_acc && !req_we && t_word == ((c == 0) ? 5'h00 : 5'h08))
            m_shadow[c] = m_wraps[c];
          if (t_cnt[c] < m_prev[c] && !m_clr_gap)
            m_wraps[c] = m_wraps[c] + 32'd1;
        end
        m_prev[c] = t_cnt[c];
      end
      m_clr_gap = m_clr;
      m_clr     = t_acc && req_we && (t_word == 5'h10) && req_wdata[0];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
      check("resp_valid", {31'd0, resp_valid}, {31'd0, m_busy});
      check("counter_clr", {31'd0, counter_clr}, {31'd0, m_clr});
      if (m_busy) begin
        check("resp_rdata", resp_rdata, m_rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, m_err});
      end
    end
  end

  task automatic xact(input logic we, input logic [4:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("latency_one", {31'd0, resp_valid}, 32'd1);
    n = 0;
    while (!resp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  logic        zero_pending;

  initial begin
    rst = 1'b1; cycle_cnt = 32'd0; inst_cnt = 32'd0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 5'd0; req_wdata = 32'd0; resp_ready = 1'b1; zero_pending = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_counter_clr", {31'd0, counter_clr}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic LO/HI loads
    cycle_cnt = 32'h10;
    @(negedge clk);
    xact(1'b0, 5'h00, 32'd0, rd, er); check("cycle_lo", rd, 32'h10);
    xact(1'b0, 5'h04, 32'd0, rd, er); check("cycle_hi_zero", rd, 32'h0);

    // Instruction counter wrap
    inst_cnt = 32'hFFFF_FFFE; @(negedge clk);
    inst_cnt = 32'hFFFF_FFFF; @(negedge clk);
    inst_cnt = 32'h0000_0003; @(negedge clk);
    @(negedge clk);
    xact(1'b0, 5'h08, 32'd0, rd, er); check("inst_lo_wrap", rd, 32'h3);
    xact(1'b0, 5'h0C, 32'd0, rd, er); check("inst_hi_wrap", rd, 32'h1);

    // Coherency: five wraps, LO load, one more wrap, then HI load
    for (int i = 0; i < 5; i++) begin
      cycle_cnt = 32'hFFFF_FFF0; @(negedge clk);
      cycle_cnt = 32'h0000_0020; @(negedge clk);
    end
    cycle_cnt = 32'h100; @(negedge clk);
    xact(1'b0, 5'h00, 32'd0, rd, er); check("coh_lo", rd, 32'h100);
    cycle_cnt = 32'hFFFF_FFFF; @(negedge clk);
    cycle_cnt = 32'h5; @(negedge clk);
    @(negedge clk);
    xact(1'b0, 5'h04, 32'd0, rd, er); check("coh_hi_snapshot", rd, 32'd5);
    xact(1'b0, 5'h00, 32'd0, rd, er); check("coh_lo2", rd, 32'd5);
    xact(1'b0, 5'h04, 32'd0, rd, er); check("coh_hi_new", rd, 32'd6);

    // Backpressure
    cycle_cnt = 32'h1234; @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h00; resp_ready = 1'b0;
    @(negedge clk);
    req_addr = 5'h08;
    check("bp_first_valid", {31'd0, resp_valid}, 32'd1);
    check("bp_first_rdata", resp_rdata, 32'h1234);
    for (int i = 0; i < 4; i++) begin
      cycle_cnt = cycle_cnt + 32'h100;
      @(negedge clk);
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
      check("bp_hold_rdata", resp_rdata, 32'h1234);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge clk); check("bp_release", {31'd0, resp_valid}, 32'd0);
    @(negedge clk); check("bp_no_extra", {31'd0, resp_valid}, 32'd0);

    // Clear pulse with upstream drop to zero
    cycle_cnt = 32'h8000_0000; inst_cnt = 32'h8000_0000; @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h10; req_wdata = 32'd1; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("clr_pulse_high", {31'd0, counter_clr}, 32'd1);
    @(negedge clk);
    check("clr_pulse_low", {31'd0, counter_clr}, 32'd0);
    cycle_cnt = 32'd0; inst_cnt = 32'd0;
    @(negedge clk); @(negedge clk);
    xact(1'b0, 5'h0C, 32'd0, rd, er); check("clr_inst_shadow", rd, 32'd0);
    xact(1'b0, 5'h08, 32'd0, rd, er); check("clr_inst_lo", rd, 32'd0);
    xact(1'b0, 5'h0C, 32'd0, rd, er); check("clr_inst_hi", rd, 32'd0);
    xact(1'b0, 5'h00, 32'd0, rd, er); check("clr_cycle_lo", rd, 32'd0);
    xact(1'b0, 5'h04, 32'd0, rd, er); check("clr_cycle_hi", rd, 32'd0);

    // Unmapped offsets and ignored stores
    xact(1'b0, 5'h14, 32'd0, rd, er);
    check("unmapped_err", {31'd0, er}, 32'd1); check("unmapped_rdata", rd, 32'd0);
    xact(1'b0, 5'h1F, 32'd0, rd, er); check("unmapped_err_1f", {31'd0, er}, 32'd1);
    xact(1'b1, 5'h00, 32'hDEAD_BEEF, rd, er);
    check("store_lo_err", {31'd0, er}, 32'd0); check("store_lo_rdata", rd, 32'd0);
    xact(1'b0, 5'h10, 32'd0, rd, er); check("ctrl_load", rd, 32'd0);

    // Reset with a response outstanding
    req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h00; resp_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_pre", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; resp_ready = 1'b1;
    @(negedge clk);

    // Randomized traffic; upstream counters emulate the clear response
    for (int i = 0; i < 3000; i++) begin
      if (zero_pending) begin
        cycle_cnt = 32'd0; inst_cnt = 32'd0; zero_pending = 1'b0;
      end else begin
        if ($urandom_range(0, 15) == 0) cycle_cnt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else cycle_cnt = cycle_cnt + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) inst_cnt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else inst_cnt = inst_cnt + 32'($urandom_range(0, 3));
      end
      if (counter_clr) zero_pending = 1'b1;
      req_valid  = ($urandom_range(0, 1) == 1);
      req_we     = ($urandom_range(0, 3) == 0);
      req_addr   = 5'($urandom_range(0, 31));
      req_wdata  = $urandom;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
